// File: rtl/register_file_multiport.sv
// Purpose : parametrised multi-port register file with per-register pending (scoreboard) bits
//           and a sequential post-reset clear sweep.
// Latency : 1 cycle read with same-cycle write forwarding; no backpressure, busy flags the sweep.
// Ports   : clk/rst (sync, active-high); rd_sel -> rd_data/rd_pending (registered);
//           wr_en/wr_sel/wr_data write ports; mark_en/mark_sel set pending; busy during sweep.
module register_file_multiport #(
  parameter int NUM_REGS     = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 3,
  parameter int NUM_WR_PORTS = 2,
  parameter int SEL_WIDTH    = $clog2(NUM_REGS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_RD_PORTS*SEL_WIDTH-1:0]  rd_sel,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]            rd_pending,
  input  logic [NUM_WR_PORTS-1:0]            wr_en,
  input  logic [NUM_WR_PORTS*SEL_WIDTH-1:0]  wr_sel,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                               mark_en,
  input  logic [SEL_WIDTH-1:0]               mark_sel,
  output logic                               busy
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                            state_q, state_d;
  logic [SEL_WIDTH-1:0]              clr_idx_q, clr_idx_d;
  logic                              busy_q, busy_d;
  logic [DATA_WIDTH-1:0]             regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]             regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]               pend_q, pend_d;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD_PORTS-1:0]           rd_pending_q, rd_pending_d;

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    busy_d       = busy_q;
    regs_d       = regs_q;
    pend_d       = pend_q;
    rd_data_d    = '0;
    rd_pending_d = '0;

    case (state_q)
      S_CLEAR: begin
        // One register per cycle; all external inputs are ignored here.
        regs_d[clr_idx_q] = '0;
        clr_idx_d         = clr_idx_q + 1'b1;
        if (clr_idx_q == SEL_WIDTH'(NUM_REGS - 1)) begin
          state_d = S_READY;
          busy_d  = 1'b0;
        end
      end

      S_READY: begin
        // Ascending port order: the highest-numbered effective port wins a conflict.
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
          if (wr_en[w] && (wr_sel[w*SEL_WIDTH +: SEL_WIDTH] != '0)) begin
            regs_d[wr_sel[w*SEL_WIDTH +: SEL_WIDTH]] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            pend_d[wr_sel[w*SEL_WIDTH +: SEL_WIDTH]] = 1'b0;
          end
        end
        // Applied after the write-clears so a new producer's mark supersedes them.
        if (mark_en && (mark_sel != '0)) begin
          pend_d[mark_sel] = 1'b1;
        end
        // Reads see the post-update state, giving same-cycle forwarding.
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
          if (rd_sel[p*SEL_WIDTH +: SEL_WIDTH] != '0) begin
            rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = regs_d[rd_sel[p*SEL_WIDTH +: SEL_WIDTH]];
            rd_pending_d[p]                       = pend_d[rd_sel[p*SEL_WIDTH +: SEL_WIDTH]];
          end
        end
      end

      default: begin
        state_d   = S_CLEAR;
        clr_idx_d = '0;
        busy_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      clr_idx_q    <= '0;
      busy_q       <= 1'b1;
      pend_q       <= '0;
      rd_data_q    <= '0;
      rd_pending_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      rd_data_q    <= rd_data_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  // Storage has no reset; the clear sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q <= regs_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_pending = rd_pending_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_register_file_multiport.sv
// Purpose : self-checking bench for register_file_multiport with a behavioural reference model.
// Latency : model predicts outputs one edge after inputs are applied.
// Backpressure: none; the sweep is tracked through busy.
module tb_register_file_multiport;
  localparam int NR  = 16;
  localparam int DW  = 32;
  localparam int NRP = 3;
  localparam int NWP = 2;
  localparam int SW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NRP*SW-1:0]   rd_sel;
  logic [NRP*DW-1:0]   rd_data;
  logic [NRP-1:0]      rd_pending;
  logic [NWP-1:0]      wr_en;
  logic [NWP*SW-1:0]   wr_sel;
  logic [NWP*DW-1:0]   wr_data;
  logic                mark_en;
  logic [SW-1:0]       mark_sel;
  logic                busy;

  register_file_multiport dut (
    .clk        (clk),
    .rst        (rst),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .mark_en    (mark_en),
    .mark_sel   (mark_sel),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents, pending set, sweep countdown.
  logic [DW-1:0] m_reg [NR];
  bit            m_pend [NR];
  bit            m_busy;
  int            m_clr;
  logic [DW-1:0] e_data [NRP];
  logic          e_pend [NRP];
  logic          e_busy;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_sel   = '0;
    wr_data  = '0;
    mark_en  = 1'b0;
    mark_sel = '0;
    rd_sel   = '0;
  endtask

  task automatic set_rd(input int p, input int sel);
    logic [SW-1:0] s;
    s = sel[SW-1:0];
    rd_sel[p*SW +: SW] = s;
  endtask

  task automatic set_wr(input int w, input int sel, input logic [DW-1:0] d);
    logic [SW-1:0] s;
    s = sel[SW-1:0];
    wr_en[w]             = 1'b1;
    wr_sel[w*SW +: SW]   = s;
    wr_data[w*DW +: DW]  = d;
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  // Advance the model by one edge using the inputs currently applied, then
  // clock the DUT and compare every output.
  task automatic cycle();
    int s;
    if (rst) begin
      m_busy = 1'b1;
      m_clr  = 0;
      for (int r = 0; r < NR; r++) m_pend[r] = 1'b0;
      for (int p = 0; p < NRP; p++) begin e_data[p] = '0; e_pend[p] = 1'b0; end
    end else if (m_busy) begin
      m_reg[m_clr] = '0;
      if (m_clr == NR - 1) m_busy = 1'b0;
      m_clr++;
      for (int p = 0; p < NRP; p++) begin e_data[p] = '0; e_pend[p] = 1'b0; end
    end else begin
      for (int w = 0; w < NWP; w++) begin
        s = int'(wr_sel[w*SW +: SW]);
        if (wr_en[w] && s != 0) begin
          m_reg[s]  = wr_data[w*DW +: DW];
          m_pend[s] = 1'b0;
        end
      end
      if (mark_en && mark_sel != 0) m_pend[mark_sel] = 1'b1;
      for (int p = 0; p < NRP; p++) begin
        s = int'(rd_sel[p*SW +: SW]);
        e_data[p] = (s == 0) ? '0 : m_reg[s];
        e_pend[p] = (s == 0) ? 1'b0 : m_pend[s];
      end
    end
    e_busy = m_busy;
    @(posedge clk);
    #1;
    check("busy", {31'b0, busy}, {31'b0, e_busy});
    for (int p = 0; p < NRP; p++) begin
      check($sformatf("rd_data%0d", p), port_data(p), e_data[p]);
      check($sformatf("rd_pending%0d", p), {31'b0, rd_pending[p]}, {31'b0, e_pend[p]});
    end
  endtask

  // Called with rst already low; counts cycles busy is observed high.
  task automatic wait_sweep();
    int cnt;
    cnt = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      idle();
      if (busy !== 1'b1) break;
      cnt++;
    end
    check("busy_cycles", cnt, NR);
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin m_reg[r] = '0; m_pend[r] = 1'b0; end
    m_busy = 1'b1;
    m_clr  = 0;
    idle();
    rst = 1'b1;

    // Reset sweep, with a write attempted during the sweep.
    @(negedge clk);
    cycle();
    cycle();
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_rd_data0", port_data(0), 32'd0);
    rst = 1'b0;
    set_wr(0, 3, 32'hDEAD);
    wait_sweep();
    for (int r = 0; r < NR; r++) begin
      set_rd(0, r);
      set_rd(1, (r + 5) % NR);
      set_rd(2, (r + 11) % NR);
      cycle();
      check("post_sweep_data", port_data(0), 32'd0);
      check("post_sweep_pend", {31'b0, rd_pending[0]}, 32'd0);
    end
    idle();
    set_rd(1, 3);
    cycle();
    check("reg3_after_sweep", port_data(1), 32'd0);

    // Basic write then read.
    idle();
    set_wr(0, 5, 32'h1234_5678);
    cycle();
    idle();
    set_rd(2, 5);
    cycle();
    check("basic_rw", port_data(2), 32'h1234_5678);

    // Forwarding with a two-port conflict.
    idle();
    set_wr(0, 7, 32'hAAAA_AAAA);
    set_wr(1, 7, 32'h5555_5555);
    for (int p = 0; p < NRP; p++) set_rd(p, 7);
    cycle();
    for (int p = 0; p < NRP; p++) check("fwd_conflict", port_data(p), 32'h5555_5555);
    idle();
    set_rd(1, 7);
    cycle();
    check("conflict_later", port_data(1), 32'h5555_5555);

    // Zero register.
    idle();
    set_wr(0, 0, 32'hFFFF_FFFF);
    mark_en = 1'b1;
    mark_sel = '0;
    for (int p = 0; p < NRP; p++) set_rd(p, 0);
    cycle();
    check("r0_fwd_data", port_data(0), 32'd0);
    check("r0_fwd_pend", {31'b0, rd_pending[0]}, 32'd0);
    idle();
    cycle();
    check("r0_later_data", port_data(2), 32'd0);
    check("r0_later_pend", {31'b0, rd_pending[2]}, 32'd0);

    // Scoreboard.
    idle();
    mark_en = 1'b1;
    mark_sel = 4'd9;
    cycle();
    idle();
    set_rd(0, 9);
    cycle();
    check("mark_r9", {31'b0, rd_pending[0]}, 32'd1);
    set_wr(1, 9, 32'h0BAD_F00D);
    mark_en = 1'b1;
    mark_sel = 4'd9;
    cycle();
    check("mark_wins", {31'b0, rd_pending[0]}, 32'd1);
    idle();
    set_rd(0, 9);
    set_wr(0, 9, 32'hCAFE_0009);
    cycle();
    check("write_clears_pend", {31'b0, rd_pending[0]}, 32'd0);
    check("write_r9_fwd", port_data(0), 32'hCAFE_0009);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      wr_en    = NWP'($urandom);
      wr_sel   = (NWP*SW)'($urandom);
      wr_data  = {$urandom, $urandom};
      mark_en  = ($urandom_range(0, 2) == 0);
      mark_sel = SW'($urandom);
      rd_sel   = (NRP*SW)'($urandom);
      cycle();
    end

    // Reset mid-operation, then again mid-sweep at index 6.
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_sweep();
    set_wr(0, 4, 32'h0000_00FF);
    mark_en = 1'b1;
    mark_sel = 4'd4;
    cycle();
    idle();
    set_rd(0, 4);
    cycle();
    check("r4_loaded", port_data(0), 32'h0000_00FF);
    check("r4_pending", {31'b0, rd_pending[0]}, 32'd1);
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_sweep();
    set_rd(0, 4);
    cycle();
    check("r4_after_reset", port_data(0), 32'd0);
    check("r4_pend_after_reset", {31'b0, rd_pending[0]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
